mips_dmem_responder: RTL

//  Responder end of the core's data-memory port: byte-addressed, little-endian storage serving

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mips_byte_ram.sv | 38 +++
 rtl/mips_dmem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory responder: FSM states,
// word size and the latched request bundle.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } t_dmem_state;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } t_mem_req;

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-wide storage: 4-lane enabled write, 4-byte combinational read.
// Ports: clk, we[3:0] lane enables, addr, wdata, rdata (addr+i wraps).
module mips_byte_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] idx [WORD_BYTES];

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      idx[i] = addr + AW'(i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we[i]) mem[idx[i]] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata[8*i +: 8] = mem[idx[i]];
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: valid/ready req and rsp channels, LATENCY
// cycles per access. Ports: clk, rst_n, req_* in, req_ready,
// rsp_valid/rdata/err out, rsp_ready in. Optional macro:
// MIPS_DMEM_ERR_CHECK_EN flags misaligned/out-of-range accesses.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW     = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  t_dmem_state state, state_nx;
  logic [3:0]  cnt;
  t_mem_req    req_in, req_q, acc;
  logic        accept, enter, err;
  logic [3:0]  lane_we;
  logic [31:0] ram_rdata;

  assign req_in = '{we: req_we, addr: req_addr,
                    wdata: req_wdata, be: req_be};
  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the
  // acceptance edge, so use the live request.
  assign acc = (state == IDLE) ? req_in : req_q;

  always_comb begin
    state_nx  = state;
    enter     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
            enter    = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = RESP;
          enter    = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MIPS_DMEM_ERR_CHECK_EN
  assign err = (acc.addr[1:0] != 2'b00) ||
               (acc.addr[31:AW] != '0);
`else
  logic unused_hi;
  assign err       = 1'b0;
  assign unused_hi = ^acc.addr[31:AW];
`endif

  assign lane_we = (enter && acc.we && !err) ? acc.be : 4'b0000;

  mips_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (lane_we),
    .addr (acc.addr[AW-1:0]),
    .wdata(acc.wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= req_in;
        cnt   <= LAT_M1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter) begin
        rsp_rdata <= (acc.we || err) ? 32'd0 : ram_rdata;
        rsp_err   <= err;
      end
    end
  end

endmodule
